// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction fetch unit: instruction/block widths,
// slots per block, the fetch FSM state encoding and the slot-extraction helper.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam int INST_W  = 16;
  localparam int BLOCK_W = 64;
  localparam int SLOTS   = 4;
  localparam int SLOT_W  = $clog2(SLOTS);

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DELIVER
  } fetch_state_e;

  // Slot 0 lives in the most significant instruction of the block.
  function automatic logic [INST_W-1:0] block_slot(input logic [BLOCK_W-1:0] blk,
                                                   input logic [SLOT_W-1:0]  slot);
    logic [INST_W-1:0] word;
    unique case (slot)
      2'd0:    word = blk[BLOCK_W-1            -: INST_W];
      2'd1:    word = blk[BLOCK_W-1-INST_W     -: INST_W];
      2'd2:    word = blk[BLOCK_W-1-(2*INST_W) -: INST_W];
      default: word = blk[BLOCK_W-1-(3*INST_W) -: INST_W];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch unit. Requests a 4-instruction block from memory, holds it
// in a line buffer and hands instructions to the consumer one at a time with a
// valid/ready handshake. A redirect restarts fetch at a new pc at any time.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   : a request waiting TIMEOUT cycles for fetchReady is reissued
//               (same address) and fetch_retry pulses for one cycle.
//   undefined : WAIT waits indefinitely, fetch_retry is tied low.
//
// Ports
//   clk            in   1   clock, all state on rising edge
//   rst            in   1   asynchronous active-high reset
//   redirect_valid in   1   restart fetch at redirect_pc
//   redirect_pc    in  16   restart instruction address
//   fetchEnable    out  1   memory request strobe (one cycle)
//   fetchAddr      out 16   block-aligned request address
//   fetchReady     in   1   memory response valid
//   fetchData      in  64   memory response, 4 x 16-bit instructions
//   inst_valid     out  1   inst / inst_pc valid
//   inst_ready     in   1   consumer accepts instruction
//   inst           out 16   instruction
//   inst_pc        out 16   address of inst
//   fetch_retry    out  1   pulse when a timed-out request is reissued
//
// State | meaning
//   REQ     | issue a request for the block containing pc
//   WAIT    | wait for the memory response
//   DELIVER | present buffered instructions from slot onwards
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [15:0]         redirect_pc,
  output logic                fetchEnable,
  output logic [15:0]         fetchAddr,
  input  logic                fetchReady,
  input  logic [BLOCK_W-1:0]  fetchData,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_W-1:0]   inst,
  output logic [15:0]         inst_pc,
  output logic                fetch_retry
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT must be at least 1");
  end

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);

  fetch_state_e        state_q;
  logic [15:0]         pc_q;
  logic [SLOT_W-1:0]   slot_q;
  logic [BLOCK_W-1:0]  line_q;
  logic                fetch_en_q;
  logic [15:0]         fetch_addr_q;
  logic                inst_valid_q;
  logic [INST_W-1:0]   inst_q;
  logic [15:0]         inst_pc_q;

  logic [15:0]         pc_d;
  logic [SLOT_W-1:0]   slot_d;

  assign pc_d   = pc_q + 16'd1;
  assign slot_d = slot_q + SLOT_W'(1);

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0]    tmo_cnt_q;
  logic                fetch_retry_q;
`endif

  // fetchEnable is registered, so it is raised on the edge that enters REQ.
  // The only REQ cycle with fetchEnable low is the first one after reset;
  // that cycle just primes the request for RESET_PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      slot_q       <= '0;
      line_q       <= '0;
      fetch_en_q   <= 1'b0;
      fetch_addr_q <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      fetch_retry_q <= 1'b0;
`endif
    end else begin
      fetch_en_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      fetch_retry_q <= 1'b0;
`endif
      if (redirect_valid) begin
        // Wins over a same-cycle response or handshake; any data in flight
        // is dropped and the buffered line is discarded.
        state_q      <= ST_REQ;
        pc_q         <= redirect_pc;
        slot_q       <= '0;
        line_q       <= '0;
        inst_valid_q <= 1'b0;
        fetch_en_q   <= 1'b1;
        fetch_addr_q <= {redirect_pc[15:2], 2'b00};
      end else begin
        unique case (state_q)
          ST_REQ: begin
            if (fetch_en_q) begin
              state_q <= ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
              tmo_cnt_q <= '0;
`endif
            end else begin
              fetch_en_q   <= 1'b1;
              fetch_addr_q <= {pc_q[15:2], 2'b00};
            end
          end

          ST_WAIT: begin
            if (fetchReady) begin
              state_q      <= ST_DELIVER;
              line_q       <= fetchData;
              slot_q       <= pc_q[1:0];
              inst_q       <= block_slot(fetchData, pc_q[1:0]);
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (tmo_cnt_q == CNT_LAST) begin
              state_q       <= ST_REQ;
              fetch_en_q    <= 1'b1;
              fetch_addr_q  <= {pc_q[15:2], 2'b00};
              fetch_retry_q <= 1'b1;
            end else begin
              tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end
`endif
          end

          ST_DELIVER: begin
            if (inst_ready) begin
              pc_q <= pc_d;
              if (slot_q == LAST_SLOT) begin
                state_q      <= ST_REQ;
                inst_valid_q <= 1'b0;
                fetch_en_q   <= 1'b1;
                fetch_addr_q <= {pc_d[15:2], 2'b00};
              end else begin
                slot_q    <= slot_d;
                inst_q    <= block_slot(line_q, slot_d);
                inst_pc_q <= pc_d;
              end
            end
          end

          default: begin
            state_q      <= ST_REQ;
            inst_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign fetchEnable = fetch_en_q;
  assign fetchAddr   = fetch_addr_q;
  assign inst_valid  = inst_valid_q;
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_retry = fetch_retry_q;
`else
  assign fetch_retry = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Scoreboard bench for fetch_unit. Stimulus pushes expected fetch addresses and
// expected {inst, inst_pc} pairs; a monitor pops and compares on every
// fetchEnable and every accepted instruction. A small memory model answers
// requests after a programmable latency. Honours FETCH_TIMEOUT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        fetchEnable;
  logic [15:0] fetchAddr;
  logic        fetchReady;
  logic [63:0] fetchData;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        fetch_retry;

  fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT(50)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetchEnable    (fetchEnable),
    .fetchAddr      (fetchAddr),
    .fetchReady     (fetchReady),
    .fetchData      (fetchData),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_retry    (fetch_retry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_fetch[$];
  logic [31:0] exp_inst[$];

  int fetch_n, fetch_first_cyc, valid_rise_cyc, hs_n, hs_first_cyc, hs_last_cyc;
  int retry_cnt, retry_cyc;
  logic valid_prev;

  // memory model state
  logic        mem_en;
  int          mem_lat;
  logic        pend;
  int          pend_cnt;
  logic [15:0] pend_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a < 16'd4) return (a + 16'd1) * 16'h1111;
    return a ^ 16'hA5A5;
  endfunction

  function automatic logic [63:0] mem_block(input logic [15:0] a);
    return {mem_word(a), mem_word(a + 16'd1), mem_word(a + 16'd2), mem_word(a + 16'd3)};
  endfunction

  task automatic push_inst(input logic [15:0] i, input logic [15:0] pc);
    exp_inst.push_back({i, pc});
  endtask

  // Memory: a request seen in cycle N is answered in cycle N + mem_lat.
  initial begin
    pend = 1'b0;
    pend_cnt = 0;
    pend_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_en) begin
        pend = 1'b0;
      end else begin
        fetchReady = 1'b0;
        if (pend) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            fetchReady = 1'b1;
            fetchData  = mem_block(pend_addr);
            pend       = 1'b0;
          end
        end
        if (fetchEnable) begin
          pend      = 1'b1;
          pend_addr = fetchAddr;
          pend_cnt  = mem_lat;
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [15:0] ea;
    logic [31:0] ei;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (fetchEnable) begin
          if (fetch_n == 0) fetch_first_cyc = cyc;
          fetch_n++;
          if (exp_fetch.size() == 0) begin
            check("unexpected_fetch", {1'b1, fetchAddr}, 17'h0);
          end else begin
            ea = exp_fetch.pop_front();
            check("fetch_addr", fetchAddr, ea);
          end
        end
        if (inst_valid && !valid_prev) valid_rise_cyc = cyc;
        valid_prev = inst_valid;
        if (inst_valid && inst_ready) begin
          if (hs_n == 0) hs_first_cyc = cyc;
          hs_last_cyc = cyc;
          hs_n++;
          if (exp_inst.size() == 0) begin
            check("unexpected_inst", {1'b1, inst, inst_pc}, 33'h0);
          end else begin
            ei = exp_inst.pop_front();
            check("inst", inst, ei[31:16]);
            check("inst_pc", inst_pc, ei[15:0]);
          end
        end
        if (fetch_retry) begin
          retry_cnt++;
          retry_cyc = cyc;
        end
      end
    end
  end

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_fetch.size() != 0 || exp_inst.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, exp_fetch.size() + exp_inst.size(), 0);
  endtask

  // Leaves rst high at a falling edge; the caller sets up and releases it.
  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {fetchEnable, fetchAddr, inst_valid, inst, inst_pc, fetch_retry}, 64'h0);
    exp_fetch.delete();
    exp_inst.delete();
    fetch_n = 0;
    hs_n = 0;
    retry_cnt = 0;
    retry_cyc = -1;
    valid_rise_cyc = -1;
    fetch_first_cyc = -1;
    valid_prev = 1'b0;
  endtask

  task automatic push_block0();
    push_inst(16'h1111, 16'h0000);
    push_inst(16'h2222, 16'h0001);
    push_inst(16'h3333, 16'h0002);
    push_inst(16'h4444, 16'h0003);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    fetchReady = 1'b0;
    fetchData = '0;
    inst_ready = 1'b0;
    mem_en = 1'b0;
    mem_lat = 2;

    // Basic stream from reset, minimum latency
    do_reset();
    mem_en = 1'b1; mem_lat = 2; inst_ready = 1'b1;
    exp_fetch.push_back(16'h0000);
    push_block0();
    exp_fetch.push_back(16'h0004);
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_fetch_after_reset", fetchEnable, 1'b1);
    drain("t1_drain", 40);
    inst_ready = 1'b0;
    check("t1_latency", valid_rise_cyc - fetch_first_cyc, 3);
    check("t1_back_to_back", hs_last_cyc - hs_first_cyc, 3);

    // Stall in slot 1
    do_reset();
    mem_en = 1'b1; mem_lat = 2; inst_ready = 1'b1;
    exp_fetch.push_back(16'h0000);
    push_block0();
    exp_fetch.push_back(16'h0004);
    rst = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (inst_valid && inst_pc == 16'h0001) break;
    end
    inst_ready = 1'b0;
    check("t2_reach_slot1", n < 20, 1'b1);
    repeat (5) begin
      @(posedge clk); #1;
      check("t2_hold", {inst_valid, inst, inst_pc}, {1'b1, 16'h2222, 16'h0001});
    end
    check("t2_no_extra_fetch", fetch_n, 1);
    inst_ready = 1'b1;
    drain("t2_drain", 40);
    inst_ready = 1'b0;

    // Redirect coinciding with fetchReady
    do_reset();
    mem_en = 1'b1; mem_lat = 2; inst_ready = 1'b1;
    exp_fetch.push_back(16'h0000);
    exp_fetch.push_back(16'h0004);
    push_inst(16'hA5A3, 16'h0006);
    push_inst(16'hA5A2, 16'h0007);
    exp_fetch.push_back(16'h0008);
    rst = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #2;
      n++;
      if (fetchReady) break;
    end
    check("t3_saw_response", n < 20, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0006;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    drain("t3_drain", 40);
    inst_ready = 1'b0;

    // pc wrap at 16'hFFFF
    do_reset();
    mem_en = 1'b1; mem_lat = 2; inst_ready = 1'b1;
    exp_fetch.push_back(16'hFFFC);
    push_inst(16'h5A59, 16'hFFFC);
    push_inst(16'h5A58, 16'hFFFD);
    push_inst(16'h5A5B, 16'hFFFE);
    push_inst(16'h5A5A, 16'hFFFF);
    exp_fetch.push_back(16'h0000);
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFC;
    rst = 1'b0;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    drain("t4_drain", 40);
    inst_ready = 1'b0;

    // Slow memory (latency 100)
    do_reset();
    mem_en = 1'b1; mem_lat = 100; inst_ready = 1'b1;
    exp_fetch.push_back(16'h0000);
`ifdef FETCH_TIMEOUT_EN
    exp_fetch.push_back(16'h0000);
`endif
    push_block0();
    exp_fetch.push_back(16'h0004);
    rst = 1'b0;
    n = 0;
    while (fetch_n == 0 && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    mem_lat = 2;
    drain("t5_drain", 250);
    inst_ready = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    check("t5_retry_count", retry_cnt, 1);
    check("t5_retry_time", retry_cyc - fetch_first_cyc, 51);
    check("t5_fetch_count", fetch_n, 3);
    check("t5_valid_time", valid_rise_cyc - fetch_first_cyc, 54);
`else
    check("t5_no_retry", retry_cnt, 0);
    check("t5_fetch_count", fetch_n, 2);
    check("t5_valid_time", valid_rise_cyc - fetch_first_cyc, 101);
`endif

    // Reset mid-WAIT, stale response after release
    do_reset();
    mem_en = 1'b1; mem_lat = 10; inst_ready = 1'b1;
    exp_fetch.push_back(16'h0000);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t6_in_wait", {fetch_n, inst_valid}, {32'd1, 1'b0});
    mem_en = 1'b0;
    do_reset();
    fetchReady = 1'b1;
    fetchData = 64'hDEAD_BEEF_CAFE_F00D;
    mem_en = 1'b1; mem_lat = 2; inst_ready = 1'b1;
    exp_fetch.push_back(16'h0000);
    push_block0();
    exp_fetch.push_back(16'h0004);
    rst = 1'b0;
    drain("t6_drain", 40);
    inst_ready = 1'b0;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
